serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised successor to the team's 4-bit serial adder.
- Adds or subtracts two WIDTH-bit two's-complement operands that arrive serially, LSB first, one bit pair per clock, through a single full-adder slice with a carry flop.
- Start/busy/done handshake; result is presented in parallel with carry-out and signed overflow.
- Sits between serial operand sources and parallel consumers in the datapath labs.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  begin operation; the cycle start is sampled carries bit 0
- mode  input  1  0 = A+B, 1 = A−B; sampled with start, held internally for the operation
- a_in  input  1  serial operand A bit, LSB first
- b_in  input  1  serial operand B bit, LSB first
- busy  output  1  high while bits 1..WIDTH-1 are being accepted
- done  output  1  one-cycle pulse; results valid from this cycle onward
- sum_out  output  WIDTH  parallel result, held until the next done
- carry_out  output  1  raw carry out of MSB; for subtract, 1 = no borrow
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: busy=0, done=0, sum_out=0, carry_out=0, overflow=0.
  - Internal state: FSM=IDLE, counter=0, shift register=0, carry flop=0.
  - Reset asserted mid-operation aborts the operation; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch mode.
  - Slice inputs: a_in, b_in XOR mode, carry-in = mode.
  - Shift sum bit 0 into the MSB of the shift register; store the carry.
  - counter=1; go to RUN.
- RUN:
  - Each edge processes one bit pair using the stored carry and latched mode; counter increments.
  - Carry into the MSB is captured when counter = WIDTH-1.
  - The edge that processes bit WIDTH-1 (edge k+WIDTH-1):
    - sum_out = completed shift register;
    - carry_out = final carry;
    - overflow = carry_into_MSB XOR final carry;
    - go to DONE.
- busy is high in RUN only.
- start, mode and changes to them in RUN are ignored; no restart or abort.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation); the next state is RUN.
  - Otherwise go to IDLE.
- Latency: start edge to done high = WIDTH clock edges. Throughput: one result per WIDTH+1 cycles; WIDTH cycles when back-to-back.
- sum_out, carry_out and overflow change only on the edge entering DONE. They hold their previous values during a new operation.
- a_in/b_in are don't-care outside the start edge and RUN.
- All arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=4, mode=0, A=3 (bits 1,1,0,0), B=5 (1,0,1,0) -> done 4 edges after start; sum_out=4'b1000, carry_out=0, overflow=1.
- WIDTH=4, mode=0, A=9, B=9 -> sum_out=4'b0010, carry_out=1, overflow=1. Then mode=1, A=5, B=3 -> sum_out=4'b0010, carry_out=1, overflow=0.
- WIDTH=4, mode=1, A=3, B=5 -> sum_out=4'b1110, carry_out=0, overflow=0. mode toggled during RUN has no effect.
- WIDTH=8, back-to-back: 0x7F+0x01, with start reasserted in the DONE cycle for 0x80−0x01:
  - 1st: done pulses, sum_out=0x80, overflow=1.
  - 2nd: done 8 edges later, sum_out=0x7F, carry_out=1, overflow=1.
  - No idle cycle between the two operations.
- WIDTH=8, start pulsed again on the 3rd RUN cycle -> ignored; a single done at the expected edge with the correct sum.
- WIDTH=8, reset driven low asynchronously mid-RUN (between edges) -> busy=0 and sum_out=0 immediately; no done. A subsequent fresh operation 0x12+0x34 yields 0x46.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement add/subtract through
// one full-adder slice and a carry flop; result presented in parallel.
module serial_addsub #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             a_in,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic             cy, cy_nx;
  logic             mode_q, mode_nx;
  logic [WIDTH-1:0] sum_nx;
  logic             co_nx, ov_nx;

  logic accept, last;
  logic m, bx, ci, s, co;

  // A start seen outside RUN carries bit 0; subtract injects carry-in 1.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);
  assign m      = accept ? mode : mode_q;
  assign bx     = b_in ^ m;
  assign ci     = accept ? mode : cy;
  assign s      = a_in ^ bx ^ ci;
  assign co     = (a_in & bx) | (a_in & ci) | (bx & ci);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    cy_nx    = cy;
    mode_nx  = mode_q;
    sum_nx   = sum_out;
    co_nx    = carry_out;
    ov_nx    = overflow;
    unique case (state)
      IDLE, DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        if (start) begin
          mode_nx  = mode;
          sr_nx    = {s, sr[WIDTH-1:1]};
          cy_nx    = co;
          cnt_nx   = CNT_W'(1);
          state_nx = RUN;
        end
      end
      RUN: begin
        sr_nx  = {s, sr[WIDTH-1:1]};
        cy_nx  = co;
        cnt_nx = cnt + CNT_W'(1);
        if (last) begin
          // cy here is the carry into the MSB
          sum_nx   = {s, sr[WIDTH-1:1]};
          co_nx    = co;
          ov_nx    = cy ^ co;
          cnt_nx   = '0;
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      cy        <= 1'b0;
      mode_q    <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sr        <= sr_nx;
      cy        <= cy_nx;
      mode_q    <= mode_nx;
      sum_out   <= sum_nx;
      carry_out <= co_nx;
      overflow  <= ov_nx;
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: drives WIDTH=4 and WIDTH=8 instances serially and
// compares against an integer-arithmetic reference model.
module tb_serial_addsub;

  logic       clk;
  logic       rst_n;
  logic       st4, md4, a4, b4;
  logic       st8, md8, a8, b8;
  logic       bz4, dn4, co4, ov4;
  logic       bz8, dn8, co8, ov8;
  logic [3:0] sm4;
  logic [7:0] sm8;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] h_sum[2];
  logic [31:0] h_co[2];
  logic [31:0] h_ov[2];

  serial_addsub #(.WIDTH(4)) u4 (
    .clk      (clk),
    .reset    (rst_n),
    .start    (st4),
    .mode     (md4),
    .a_in     (a4),
    .b_in     (b4),
    .busy     (bz4),
    .done     (dn4),
    .sum_out  (sm4),
    .carry_out(co4),
    .overflow (ov4)
  );

  serial_addsub #(.WIDTH(8)) u8 (
    .clk      (clk),
    .reset    (rst_n),
    .start    (st8),
    .mode     (md8),
    .a_in     (a8),
    .b_in     (b8),
    .busy     (bz8),
    .done     (dn8),
    .sum_out  (sm8),
    .carry_out(co8),
    .overflow (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] o_sum(input int w);
    return (w == 4) ? 32'(sm4) : 32'(sm8);
  endfunction
  function automatic logic [31:0] o_busy(input int w);
    return (w == 4) ? 32'(bz4) : 32'(bz8);
  endfunction
  function automatic logic [31:0] o_done(input int w);
    return (w == 4) ? 32'(dn4) : 32'(dn8);
  endfunction
  function automatic logic [31:0] o_co(input int w);
    return (w == 4) ? 32'(co4) : 32'(co8);
  endfunction
  function automatic logic [31:0] o_ov(input int w);
    return (w == 4) ? 32'(ov4) : 32'(ov8);
  endfunction

  task automatic drv(input int w, input logic st, input logic m,
                     input logic a, input logic b);
    if (w == 4) begin
      st4 = st; md4 = m; a4 = a; b4 = b;
    end else begin
      st8 = st; md8 = m; a8 = a; b8 = b;
    end
  endtask

  // Reference: unsigned/signed integer arithmetic on the whole operands.
  task automatic model(input int w, input logic [31:0] a,
                       input logic [31:0] b, input logic m,
                       output logic [31:0] s, output logic [31:0] c,
                       output logic [31:0] v);
    longint full = longint'(1) << w;
    longint half = full >> 1;
    longint ua = longint'(a) & (full - 1);
    longint ub = longint'(b) & (full - 1);
    longint sa = (ua >= half) ? ua - full : ua;
    longint sb = (ub >= half) ? ub - full : ub;
    longint r  = m ? ua - ub : ua + ub;
    longint sr = m ? sa - sb : sa + sb;
    s = 32'(r & (full - 1));
    c = m ? 32'(ua >= ub) : 32'(ua + ub >= full);
    v = 32'((sr < -half) || (sr >= half));
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic op(input int w, input logic [31:0] a,
                    input logic [31:0] b, input logic m, input int jk);
    logic [31:0] es, ec, ev;
    int x = (w == 4) ? 0 : 1;
    model(w, a, b, m, es, ec, ev);
    drv(w, 1'b1, m, a[0], b[0]);
    for (int i = 1; i < w; i++) begin
      @(negedge clk);
      chk("busy", o_busy(w), 1);
      chk("done_early", o_done(w), 0);
      chk("hold_sum", o_sum(w), h_sum[x]);
      chk("hold_co", o_co(w), h_co[x]);
      drv(w, i == jk, 1'($urandom), a[i], b[i]);
    end
    @(negedge clk);
    chk("done", o_done(w), 1);
    chk("busy_in_done", o_busy(w), 0);
    chk("sum", o_sum(w), es);
    chk("carry", o_co(w), ec);
    chk("ovf", o_ov(w), ev);
    h_sum[x] = es;
    h_co[x]  = ec;
    h_ov[x]  = ev;
    drv(w, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic gap(input int w, input int n);
    int x = (w == 4) ? 0 : 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done", o_done(w), 0);
      chk("idle_busy", o_busy(w), 0);
      chk("idle_sum", o_sum(w), h_sum[x]);
      chk("idle_ovf", o_ov(w), h_ov[x]);
      drv(w, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int w = 4; w <= 8; w += 4) begin
      chk({tag, "_busy"}, o_busy(w), 0);
      chk({tag, "_done"}, o_done(w), 0);
      chk({tag, "_sum"}, o_sum(w), 0);
      chk({tag, "_co"}, o_co(w), 0);
      chk({tag, "_ov"}, o_ov(w), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drv(4, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      h_sum[i] = '0; h_co[i] = '0; h_ov[i] = '0;
    end
    #3;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(4, 3, 5, 1'b0, 0);
    gap(4, 2);
    op(4, 9, 9, 1'b0, 0);
    gap(4, 1);
    op(4, 5, 3, 1'b1, 0);
    gap(4, 1);
    op(4, 3, 5, 1'b1, 0);
    gap(4, 2);

    op(8, 32'h7F, 32'h01, 1'b0, 0);
    op(8, 32'h80, 32'h01, 1'b1, 0);
    gap(8, 2);

    op(8, 32'hC3, 32'h2A, 1'b0, 3);
    gap(8, 1);

    // Abort mid-run with an asynchronous reset between edges.
    drv(8, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drv(8, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drv(8, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    for (int i = 0; i < 2; i++) begin
      h_sum[i] = '0; h_co[i] = '0; h_ov[i] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    gap(8, 10);
    op(8, 32'h12, 32'h34, 1'b0, 0);
    gap(8, 1);

    for (int k = 0; k < 40; k++) begin
      int w = $urandom_range(0, 1) ? 8 : 4;
      op(w, $urandom, $urandom, 1'($urandom), $urandom_range(0, w - 1));
      if ($urandom_range(0, 2) == 0) gap(w, $urandom_range(1, 3));
    end
    gap(4, 1);
    gap(8, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
